// File: rtl/rv32_mem_access.sv
// rv32 memory stage: drives the data bus, then aligns and registers load/store results for
// writeback. Define RV32_MEM_TIMEOUT_EN to fault requests the bus leaves hanging.
module rv32_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  exception_cause_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] store_value_in,
  input  logic        data_ready_in,
  input  logic        data_fault_in,
  input  logic [31:0] data_read_value_in,
  output logic        data_valid_out,
  output logic        data_write_out,
  output logic [31:0] data_address_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  output logic        stall_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  exception_cause_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out
);

  typedef enum logic [0:0] {StIdle, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        buf_fault_q, buf_fault_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [3:0]  cause_q, cause_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_write_q, rd_write_d;
  logic [31:0] rd_value_q, rd_value_d;

  logic [1:0]  offset;
  logic        is_store, access, misaligned, mis_access;
  logic        issue_ok, req, handshake, timeout_hit, bus_fault, fault_now, exc_next, upd;
  logic [31:0] shifted, aligned_load, load_data, wdata;
  logic [3:0]  mask;

  assign offset   = result_in[1:0];
  assign is_store = mem_write_in;
  assign access   = valid_in & ~exception_in & ~flush_in & (mem_read_in | mem_write_in);

  always_comb begin
    case (mem_width_in)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      default: misaligned = |offset;
    endcase
  end

  assign mis_access = access & misaligned;
  assign issue_ok   = access & ~misaligned & (state_q == StIdle) & ~reset;

`ifdef RV32_MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The timeout cycle itself withdraws the request and completes it with a fault.
  assign timeout_hit = issue_ok & (cnt_q == TimeoutCnt);
  assign cnt_d       = stall_out ? cnt_q + 1'b1 : '0;
`else
  assign timeout_hit = 1'b0;
`endif

  assign req       = issue_ok & ~timeout_hit;
  assign handshake = req & data_ready_in;
  assign stall_out = req & ~data_ready_in;
  assign upd       = ~stall_in & ~stall_out;

  always_comb begin
    case (mem_width_in)
      2'd0: begin
        mask  = 4'b0001 << offset;
        wdata = {4{store_value_in[7:0]}};
      end
      2'd1: begin
        mask  = 4'b0011 << offset;
        wdata = {2{store_value_in[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        wdata = store_value_in;
      end
    endcase
  end

  assign data_valid_out       = req;
  assign data_write_out       = req & is_store;
  assign data_address_out     = req ? {result_in[31:2], 2'b00} : 32'd0;
  assign data_write_mask_out  = (req & is_store) ? mask : 4'd0;
  assign data_write_value_out = (req & is_store) ? wdata : 32'd0;

  always_comb begin
    shifted = data_read_value_in >> {offset, 3'b000};
    case (mem_width_in)
      2'd0:    aligned_load = {{24{~mem_zero_extend_in & shifted[7]}}, shifted[7:0]};
      2'd1:    aligned_load = {{16{~mem_zero_extend_in & shifted[15]}}, shifted[15:0]};
      default: aligned_load = shifted;
    endcase
  end

  assign bus_fault = (handshake & data_fault_in) | timeout_hit;
  assign fault_now = (state_q == StDone) ? (buf_fault_q & ~flush_in) : bus_fault;
  assign load_data = (state_q == StDone) ? buf_data_q : aligned_load;
  assign exc_next  = exception_in | mis_access | fault_now;

  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_fault_d = buf_fault_q;
    unique case (state_q)
      StIdle: begin
        // Completion while downstream is stalled: park the result, never re-issue.
        if ((handshake | timeout_hit) & stall_in) begin
          state_d     = StDone;
          buf_data_d  = aligned_load;
          buf_fault_d = bus_fault;
        end
      end
      StDone: begin
        if (flush_in | ~stall_in) begin
          state_d     = StIdle;
          buf_data_d  = 32'd0;
          buf_fault_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    exc_d      = exc_q;
    cause_d    = cause_q;
    rd_d       = rd_q;
    rd_write_d = rd_write_q;
    rd_value_d = rd_value_q;
    if (upd) begin
      valid_d    = valid_in & ~flush_in;
      exc_d      = exc_next;
      rd_d       = rd_in;
      rd_write_d = rd_write_in & ~flush_in & ~exc_next;
      rd_value_d = mem_read_in ? load_data : result_in;
      if (exception_in)    cause_d = exception_cause_in;
      else if (mis_access) cause_d = is_store ? 4'd6 : 4'd4;
      else if (fault_now)  cause_d = is_store ? 4'd7 : 4'd5;
      else                 cause_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      buf_data_q  <= 32'd0;
      buf_fault_q <= 1'b0;
      valid_q     <= 1'b0;
      exc_q       <= 1'b0;
      cause_q     <= 4'd0;
      rd_q        <= 5'd0;
      rd_write_q  <= 1'b0;
      rd_value_q  <= 32'd0;
`ifdef RV32_MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_fault_q <= buf_fault_d;
      valid_q     <= valid_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
      rd_q        <= rd_d;
      rd_write_q  <= rd_write_d;
      rd_value_q  <= rd_value_d;
`ifdef RV32_MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign valid_out           = valid_q;
  assign exception_out       = exc_q;
  assign exception_cause_out = cause_q;
  assign rd_out              = rd_q;
  assign rd_write_out        = rd_write_q;
  assign rd_value_out        = rd_value_q;

endmodule

// File: tb/tb_rv32_mem_access.sv
// Randomised and directed bench for rv32_mem_access against a behavioural access model.
module tb_rv32_mem_access;

  logic        clk, reset, stall_in, flush_in, valid_in, exception_in;
  logic [3:0]  exception_cause_in;
  logic        mem_read_in, mem_write_in, mem_zero_extend_in, rd_write_in;
  logic [1:0]  mem_width_in;
  logic [4:0]  rd_in;
  logic [31:0] result_in, store_value_in, data_read_value_in;
  logic        data_ready_in, data_fault_in;
  logic        data_valid_out, data_write_out, stall_out, valid_out, exception_out, rd_write_out;
  logic [31:0] data_address_out, data_write_value_out, rd_value_out;
  logic [3:0]  data_write_mask_out, exception_cause_out;
  logic [4:0]  rd_out;

  int tests_run, tests_failed;

  rv32_mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
    .exception_in(exception_in), .exception_cause_in(exception_cause_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
    .mem_zero_extend_in(mem_zero_extend_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .result_in(result_in), .store_value_in(store_value_in), .data_ready_in(data_ready_in),
    .data_fault_in(data_fault_in), .data_read_value_in(data_read_value_in),
    .data_valid_out(data_valid_out), .data_write_out(data_write_out),
    .data_address_out(data_address_out), .data_write_mask_out(data_write_mask_out),
    .data_write_value_out(data_write_value_out), .stall_out(stall_out), .valid_out(valid_out),
    .exception_out(exception_out), .exception_cause_out(exception_cause_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .rd_value_out(rd_value_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the access rules.
  function automatic logic model_mis(input logic [1:0] w, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (w == 2'd0) return 1'b0;
    if (w == 2'd1) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] w, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (w == 2'd0) return 4'(1 << off);
    if (w == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
    if (w == 2'd0) return (d % 256) * 32'h0101_0101;
    if (w == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] w, input logic zx);
    logic [31:0] v;
    v = word >> (8 * int'(addr % 4));
    if (w == 2'd0) begin
      v = v % 256;
      if (!zx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = v % 65536;
      if (!zx && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic set_idle();
    valid_in = 0; exception_in = 0; exception_cause_in = 0; mem_read_in = 0; mem_write_in = 0;
    mem_width_in = 0; mem_zero_extend_in = 0; rd_in = 0; rd_write_in = 0; result_in = 0;
    store_value_in = 0; data_ready_in = 0; data_fault_in = 0; data_read_value_in = 0;
    stall_in = 0; flush_in = 0;
  endtask

  // Drives one access until it completes (or issues nothing) and reports what the bus saw.
  task automatic do_access(input logic st, input logic [1:0] w, input logic zx,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input logic flt, input logic [4:0] rd,
                           input logic rdw, input int delay,
                           output int stalls, output int hs, output logic dv_seen,
                           output logic [3:0] mask_seen, output logic [31:0] wval_seen,
                           output logic [31:0] addr_seen, output logic wr_seen);
    int cyc;
    logic dv_s, rdy_s;
    valid_in = 1; mem_read_in = ~st; mem_write_in = st; mem_width_in = w;
    mem_zero_extend_in = zx; result_in = addr; store_value_in = sdata; rd_in = rd;
    rd_write_in = rdw; data_read_value_in = rdata; data_fault_in = flt;
    data_ready_in = (delay == 0);
    stalls = 0; hs = 0; dv_seen = 0; mask_seen = 0; wval_seen = 0; addr_seen = 0; wr_seen = 0;
    cyc = 0;
    forever begin
      #1;
      dv_s = data_valid_out;
      rdy_s = data_ready_in;
      if (dv_s && !dv_seen) begin
        dv_seen = 1; mask_seen = data_write_mask_out; wval_seen = data_write_value_out;
        addr_seen = data_address_out; wr_seen = data_write_out;
      end
      if (stall_out) stalls++;
      if (dv_s && rdy_s) hs++;
      @(posedge clk); #1;
      cyc++;
      if (!dv_s || rdy_s) break;
      if (cyc > 60) begin
        tests_run++; tests_failed++;
        $display("FAIL access_bound: no completion after %0d cycles, required within 60", cyc);
        break;
      end
      data_ready_in = (cyc >= delay);
    end
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    valid_in = 1; mem_read_in = 1; mem_width_in = 2; result_in = 32'h100; rd_in = 5;
    rd_write_in = 1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++;
      $display("FAIL rst_dv: got %b want 0", data_valid_out); end
    tests_run++; if (stall_out !== 1'b0) begin tests_failed++;
      $display("FAIL rst_stall: got %b want 0", stall_out); end
    tests_run++; if ({valid_out, exception_out, exception_cause_out, rd_out, rd_write_out,
                      rd_value_out} !== 43'd0) begin tests_failed++;
      $display("FAIL rst_regs: got v%b e%b c%h rd%h w%b val%h want all 0", valid_out,
               exception_out, exception_cause_out, rd_out, rd_write_out, rd_value_out); end
    reset = 0;
    set_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    int st, hs; logic dv, wr; logic [3:0] m; logic [31:0] wv, a;
    do_access(1, 2, 0, 32'h1004, 32'hDEAD_BEEF, 0, 0, 5'd0, 0, 0, st, hs, dv, m, wv, a, wr);
    tests_run++; if (dv !== 1'b1 || wr !== 1'b1) begin tests_failed++;
      $display("FAIL sw_req: got dv=%b wr=%b want 1 1", dv, wr); end
    tests_run++; if (m !== 4'hF) begin tests_failed++;
      $display("FAIL sw_mask: got %b want 1111", m); end
    tests_run++; if (a !== 32'h1004 || wv !== 32'hDEAD_BEEF) begin tests_failed++;
      $display("FAIL sw_addr_data: got %h/%h want 00001004/deadbeef", a, wv); end
    tests_run++; if (st !== 0 || hs !== 1) begin tests_failed++;
      $display("FAIL sw_stall: got stalls=%0d hs=%0d want 0 1", st, hs); end
    tests_run++; if (valid_out !== 1'b1 || rd_write_out !== 1'b0 || exception_out !== 1'b0)
      begin tests_failed++;
      $display("FAIL sw_out: got v=%b w=%b e=%b want 1 0 0", valid_out, rd_write_out,
               exception_out); end
  endtask

  task automatic test_byte_load_wait();
    int st, hs; logic dv, wr; logic [3:0] m; logic [31:0] wv, a;
    do_access(0, 0, 0, 32'h2003, 0, 32'h8012_3456, 0, 5'd7, 1, 3, st, hs, dv, m, wv, a, wr);
    tests_run++; if (st !== 3 || hs !== 1) begin tests_failed++;
      $display("FAIL lb_stall: got stalls=%0d hs=%0d want 3 1", st, hs); end
    tests_run++; if (m !== 4'h0 || wr !== 1'b0) begin tests_failed++;
      $display("FAIL lb_rdmask: got mask=%b wr=%b want 0000 0", m, wr); end
    tests_run++; if (rd_value_out !== 32'hFFFF_FF80 || rd_out !== 5'd7 || rd_write_out !== 1'b1)
      begin tests_failed++;
      $display("FAIL lb_value: got %h rd=%0d w=%b want ffffff80 7 1", rd_value_out, rd_out,
               rd_write_out); end
    do_access(0, 0, 1, 32'h2003, 0, 32'h8012_3456, 0, 5'd7, 1, 3, st, hs, dv, m, wv, a, wr);
    tests_run++; if (rd_value_out !== 32'h0000_0080) begin tests_failed++;
      $display("FAIL lbu_value: got %h want 00000080", rd_value_out); end
  endtask

  task automatic test_misaligned();
    int st, hs; logic dv, wr; logic [3:0] m; logic [31:0] wv, a;
    do_access(0, 1, 0, 32'h2001, 0, 0, 0, 5'd4, 1, 0, st, hs, dv, m, wv, a, wr);
    tests_run++; if (dv !== 1'b0 || hs !== 0) begin tests_failed++;
      $display("FAIL lh_mis_req: got dv=%b hs=%0d want 0 0", dv, hs); end
    tests_run++; if (exception_out !== 1'b1 || exception_cause_out !== 4'd4 ||
                     rd_write_out !== 1'b0) begin tests_failed++;
      $display("FAIL lh_mis_exc: got e=%b c=%0d w=%b want 1 4 0", exception_out,
               exception_cause_out, rd_write_out); end
    do_access(0, 2, 0, 32'h2002, 0, 0, 0, 5'd4, 1, 0, st, hs, dv, m, wv, a, wr);
    tests_run++; if (dv !== 1'b0 || exception_cause_out !== 4'd4) begin tests_failed++;
      $display("FAIL lw_mis: got dv=%b c=%0d want 0 4", dv, exception_cause_out); end
    do_access(1, 2, 0, 32'h2001, 0, 0, 0, 5'd0, 0, 0, st, hs, dv, m, wv, a, wr);
    tests_run++; if (dv !== 1'b0 || exception_cause_out !== 4'd6) begin tests_failed++;
      $display("FAIL sw_mis: got dv=%b c=%0d want 0 6", dv, exception_cause_out); end
  endtask

  task automatic test_bus_fault();
    int st, hs; logic dv, wr; logic [3:0] m; logic [31:0] wv, a;
    do_access(1, 1, 0, 32'h3002, 32'h0000_BEEF, 0, 1, 5'd2, 1, 0, st, hs, dv, m, wv, a, wr);
    tests_run++; if (m !== 4'b1100 || wv !== 32'hBEEF_BEEF) begin tests_failed++;
      $display("FAIL sh_bus: got mask=%b data=%h want 1100 beefbeef", m, wv); end
    tests_run++; if (exception_out !== 1'b1 || exception_cause_out !== 4'd7 ||
                     rd_write_out !== 1'b0) begin tests_failed++;
      $display("FAIL sh_fault: got e=%b c=%0d w=%b want 1 7 0", exception_out,
               exception_cause_out, rd_write_out); end
  endtask

  task automatic test_stall_complete();
    int hs = 0;
    valid_in = 1; result_in = 32'hAAAA_5555; rd_in = 3; rd_write_in = 1;
    @(posedge clk); #1;
    set_idle();
    tests_run++; if (rd_value_out !== 32'hAAAA_5555 || rd_write_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_pass: got %h w=%b want aaaa5555 1", rd_value_out, rd_write_out); end
    valid_in = 1; mem_read_in = 1; mem_width_in = 2; result_in = 32'h4000; rd_in = 9;
    rd_write_in = 1; data_read_value_in = 32'h1234_5678; data_ready_in = 1; stall_in = 1;
    #1; if (data_valid_out && data_ready_in) hs++;
    tests_run++; if (stall_out !== 1'b0) begin tests_failed++;
      $display("FAIL stc_zero_lat: got stall=%b want 0", stall_out); end
    @(posedge clk); #1;
    data_read_value_in = 32'hFFFF_FFFF;
    #1; if (data_valid_out && data_ready_in) hs++;
    @(posedge clk); #1;
    tests_run++; if (rd_value_out !== 32'hAAAA_5555) begin tests_failed++;
      $display("FAIL stc_hold: got %h want aaaa5555", rd_value_out); end
    stall_in = 0;
    #1; if (data_valid_out && data_ready_in) hs++;
    @(posedge clk); #1;
    set_idle();
    tests_run++; if (hs !== 1) begin tests_failed++;
      $display("FAIL stc_handshakes: got %0d want 1", hs); end
    tests_run++; if (rd_value_out !== 32'h1234_5678 || rd_out !== 5'd9 ||
                     rd_write_out !== 1'b1 || exception_out !== 1'b0) begin tests_failed++;
      $display("FAIL stc_capture: got %h rd=%0d w=%b e=%b want 12345678 9 1 0", rd_value_out,
               rd_out, rd_write_out, exception_out); end
  endtask

  task automatic test_flush();
    valid_in = 1; mem_read_in = 1; mem_width_in = 2; result_in = 32'h5000; rd_in = 6;
    rd_write_in = 1;
    #1;
    tests_run++; if (data_valid_out !== 1'b1 || stall_out !== 1'b1) begin tests_failed++;
      $display("FAIL fl_wait: got dv=%b stall=%b want 1 1", data_valid_out, stall_out); end
    @(posedge clk); #1;
    flush_in = 1;
    #1;
    tests_run++; if (data_valid_out !== 1'b0 || stall_out !== 1'b0) begin tests_failed++;
      $display("FAIL fl_drop: got dv=%b stall=%b want 0 0", data_valid_out, stall_out); end
    @(posedge clk); #1;
    set_idle();
    tests_run++; if (valid_out !== 1'b0 || rd_write_out !== 1'b0 || exception_out !== 1'b0)
      begin tests_failed++;
      $display("FAIL fl_out: got v=%b w=%b e=%b want 0 0 0", valid_out, rd_write_out,
               exception_out); end
  endtask

  task automatic test_passthrough();
    valid_in = 1; exception_in = 1; exception_cause_in = 4'd2; mem_write_in = 1;
    mem_width_in = 2; result_in = 32'h7000; rd_write_in = 1; data_ready_in = 1;
    #1;
    tests_run++; if (data_valid_out !== 1'b0) begin tests_failed++;
      $display("FAIL pt_bus: got dv=%b want 0", data_valid_out); end
    @(posedge clk); #1;
    set_idle();
    tests_run++; if (exception_out !== 1'b1 || exception_cause_out !== 4'd2 ||
                     valid_out !== 1'b1 || rd_write_out !== 1'b0) begin tests_failed++;
      $display("FAIL pt_out: got e=%b c=%0d v=%b w=%b want 1 2 1 0", exception_out,
               exception_cause_out, valid_out, rd_write_out); end
  endtask

  task automatic test_random();
    int st, hs, delay; logic dv, wr; logic [3:0] m; logic [31:0] wv, a;
    logic sto, zx, flt, rdw, mis, e_exc; logic [1:0] w; logic [4:0] rd;
    logic [31:0] addr, sd, rdata, e_val; logic [3:0] e_cause;
    for (int i = 0; i < 40; i++) begin
      sto = 1'($urandom); w = 2'($urandom); zx = 1'($urandom); addr = $urandom;
      sd = $urandom; rdata = $urandom; flt = ($urandom_range(0, 5) == 0); rd = 5'($urandom);
      rdw = ~sto; delay = $urandom_range(0, 3);
      do_access(sto, w, zx, addr, sd, rdata, flt, rd, rdw, delay, st, hs, dv, m, wv, a, wr);
      mis = model_mis(w, addr);
      e_exc = mis | flt;
      e_cause = mis ? (sto ? 4'd6 : 4'd4) : (flt ? (sto ? 4'd7 : 4'd5) : 4'd0);
      e_val = sto ? addr : model_load(rdata, addr, w, zx);
      tests_run++; if (hs !== (mis ? 0 : 1) || st !== (mis ? 0 : delay)) begin tests_failed++;
        $display("FAIL rnd%0d_hs: got hs=%0d stalls=%0d want %0d %0d", i, hs, st, !mis,
                 mis ? 0 : delay); end
      tests_run++; if (exception_out !== e_exc || exception_cause_out !== e_cause ||
                       valid_out !== 1'b1) begin tests_failed++;
        $display("FAIL rnd%0d_exc: got e=%b c=%0d v=%b want %b %0d 1", i, exception_out,
                 exception_cause_out, valid_out, e_exc, e_cause); end
      tests_run++; if (rd_write_out !== (rdw & ~e_exc) || rd_out !== rd) begin tests_failed++;
        $display("FAIL rnd%0d_rd: got w=%b rd=%0d want %b %0d", i, rd_write_out, rd_out,
                 rdw & ~e_exc, rd); end
      if (!e_exc) begin
        tests_run++; if (rd_value_out !== e_val) begin tests_failed++;
          $display("FAIL rnd%0d_val: got %h want %h (w=%0d a=%h zx=%b)", i, rd_value_out,
                   e_val, w, addr, zx); end
      end
      if (!mis) begin
        tests_run++; if (a !== (addr & 32'hFFFF_FFFC) || wr !== sto ||
                         m !== (sto ? model_mask(w, addr) : 4'h0) ||
                         (sto && wv !== model_wdata(w, sd))) begin tests_failed++;
          $display("FAIL rnd%0d_bus: got a=%h wr=%b m=%b d=%h want a=%h wr=%b m=%b d=%h", i,
                   a, wr, m, wv, addr & 32'hFFFF_FFFC, sto, sto ? model_mask(w, addr) : 4'h0,
                   model_wdata(w, sd)); end
      end
    end
  endtask

`ifdef RV32_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int st, hs; logic dv, wr; logic [3:0] m; logic [31:0] wv, a;
    do_access(0, 2, 0, 32'h8000, 0, 0, 0, 5'd1, 1, 100, st, hs, dv, m, wv, a, wr);
    tests_run++; if (st !== 4 || hs !== 0) begin tests_failed++;
      $display("FAIL to_stall: got stalls=%0d hs=%0d want 4 0", st, hs); end
    tests_run++; if (exception_out !== 1'b1 || exception_cause_out !== 4'd5 ||
                     rd_write_out !== 1'b0) begin tests_failed++;
      $display("FAIL to_exc: got e=%b c=%0d w=%b want 1 5 0", exception_out,
               exception_cause_out, rd_write_out); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    valid_in = 1; mem_read_in = 1; mem_width_in = 2; result_in = 32'h6000; rd_in = 8;
    rd_write_in = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    tests_run++; if (data_valid_out !== 1'b0 || stall_out !== 1'b0) begin tests_failed++;
      $display("FAIL rmw_req: got dv=%b stall=%b want 0 0", data_valid_out, stall_out); end
    @(posedge clk); #1;
    tests_run++; if ({valid_out, exception_out, exception_cause_out, rd_out, rd_write_out,
                      rd_value_out, data_address_out, data_write_mask_out} !== 79'd0) begin
      tests_failed++;
      $display("FAIL rmw_regs: got v%b e%b c%h rd%h w%b val%h a%h m%b want all 0", valid_out,
               exception_out, exception_cause_out, rd_out, rd_write_out, rd_value_out,
               data_address_out, data_write_mask_out); end
    reset = 0;
    set_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    set_idle();
    reset = 1;
    test_reset();
    test_word_store();
    test_byte_load_wait();
    test_misaligned();
    test_bus_fault();
    test_stall_complete();
    test_flush();
    test_passthrough();
    test_random();
`ifdef RV32_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
